// File: rtl/cprv_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// cprv_dmem_arbiter
//   Shares one memory port between two requesters:
//     port 0 = instruction fetch, port 1 = mem stage.
//   Each request is accepted through a valid/ready handshake and registered onto
//   mem_*. A grant can only go out when the output register is free or draining.
//   Each accepted load pushes its port number (its grant tag) into an ID FIFO.
//   Memory read responses are then routed combinationally, in order, to the port
//   at the head of that FIFO.
//
// Optional feature (compile-time macro):
//   CPRV_ARB_FIXED_PRIO_EN - port 1 always wins when it is valid and eligible,
//                            and no last-grant state is kept. Port 0 can starve.
//                            When undefined (the default build), arbitration is
//                            round-robin.
//
// Parameters:
//   DATA_WIDTH - width of addr, wdata and rdata
//   MAX_OUTS   - maximum number of outstanding reads; also the ID FIFO depth.
//                Must be a power of 2 and >= 2.
//
// Ports:
//   clk, rst_n               clock; asynchronous active-low reset
//   req_valid_i/ready_o[1:0] request handshake, one bit per port
//   req_addr_i/wdata_i[1:0]  request address and store data, per port
//   req_w_en_i[1:0]          1 = store, 0 = load
//   rsp_valid_o/ready_i[1:0] read response handshake, per port
//   rsp_rdata_o[1:0]         read data; both ports are driven from mem_rdata_i
//   mem_valid_o/ready_i      registered request to memory
//   mem_addr/wdata/w_en_o    registered request payload
//   mem_rsp_valid_i/ready_o  memory read response handshake
//   mem_rdata_i              memory read data
// -----------------------------------------------------------------------------
module cprv_dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_OUTS   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_valid_i,
  output logic [1:0]                 req_ready_o,
  input  logic [1:0][DATA_WIDTH-1:0] req_addr_i,
  input  logic [1:0][DATA_WIDTH-1:0] req_wdata_i,
  input  logic [1:0]                 req_w_en_i,
  output logic [1:0]                 rsp_valid_o,
  input  logic [1:0]                 rsp_ready_i,
  output logic [1:0][DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                       mem_valid_o,
  input  logic                       mem_ready_i,
  output logic [DATA_WIDTH-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0]      mem_wdata_o,
  output logic                       mem_w_en_o,
  input  logic                       mem_rsp_valid_i,
  output logic                       mem_rsp_ready_o,
  input  logic [DATA_WIDTH-1:0]      mem_rdata_i
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTS);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic                  r_mem_valid;
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_mem_w_en;
  logic [MAX_OUTS-1:0]   r_tag;
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
`ifndef CPRV_ARB_FIXED_PRIO_EN
  logic                  r_last_grant;
`endif

  logic       w_cke;
  logic       w_empty;
  logic       w_has_room;
  logic [1:0] w_elig;
  logic       w_win;
  logic       w_grant;
  logic       w_head;
  logic       w_push;
  logic       w_pop;

  assign w_cke      = ~r_mem_valid | mem_ready_i;
  assign w_empty    = (r_count == '0);
  // Uses the count before any pop in the same cycle.
  assign w_has_room = (r_count < CNT_W'(MAX_OUTS));
  assign w_head     = r_tag[r_rptr];

  always_comb begin
    // Eligibility is decided per port, so a load that is blocked by a full FIFO
    // drops out of arbitration and a store from the other port can still win.
    w_elig[0] = req_valid_i[0] & (req_w_en_i[0] | w_has_room);
    w_elig[1] = req_valid_i[1] & (req_w_en_i[1] | w_has_room);
`ifdef CPRV_ARB_FIXED_PRIO_EN
    w_win = w_elig[1];
`else
    w_win = (&w_elig) ? ~r_last_grant : w_elig[1];
`endif
    w_grant = w_cke & (|w_elig);

    req_ready_o = '0;
    if (w_grant) begin
      req_ready_o[w_win] = 1'b1;
    end

    rsp_valid_o = '0;
    rsp_valid_o[w_head] = mem_rsp_valid_i & ~w_empty;
    mem_rsp_ready_o = ~w_empty & rsp_ready_i[w_head];

    w_push = w_grant & ~req_w_en_i[w_win];
    w_pop  = mem_rsp_valid_i & mem_rsp_ready_o;
  end

  assign rsp_rdata_o[0] = mem_rdata_i;
  assign rsp_rdata_o[1] = mem_rdata_i;

  assign mem_valid_o = r_mem_valid;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_w_en_o  = r_mem_w_en;

  // Output register for the request path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_valid  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_w_en   <= 1'b0;
`ifndef CPRV_ARB_FIXED_PRIO_EN
      r_last_grant <= 1'b1;
`endif
    end else if (w_cke) begin
      r_mem_valid <= w_grant;
      if (w_grant) begin
        r_mem_addr   <= req_addr_i[w_win];
        r_mem_wdata  <= req_wdata_i[w_win];
        r_mem_w_en   <= req_w_en_i[w_win];
`ifndef CPRV_ARB_FIXED_PRIO_EN
        r_last_grant <= w_win;
`endif
      end
    end
  end

  // ID FIFO of grant tags; pointers wrap naturally because MAX_OUTS is 2^PTR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tag[r_wptr] <= w_win;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_cprv_dmem_arbiter.sv
module tb_cprv_dmem_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic [1:0][63:0] req_addr_i;
  logic [1:0][63:0] req_wdata_i;
  logic [1:0]       req_w_en_i;
  logic [1:0]       rsp_valid_o;
  logic [1:0]       rsp_ready_i;
  logic [1:0][63:0] rsp_rdata_o;
  logic             mem_valid_o;
  logic             mem_ready_i;
  logic [63:0]      mem_addr_o;
  logic [63:0]      mem_wdata_o;
  logic             mem_w_en_o;
  logic             mem_rsp_valid_i;
  logic             mem_rsp_ready_o;
  logic [63:0]      mem_rdata_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cprv_dmem_arbiter #(.DATA_WIDTH(64), .MAX_OUTS(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_wdata_i     (req_wdata_i),
    .req_w_en_i      (req_w_en_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_rdata_o     (rsp_rdata_o),
    .mem_valid_o     (mem_valid_o),
    .mem_ready_i     (mem_ready_i),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_w_en_o      (mem_w_en_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_ready_o (mem_rsp_ready_o),
    .mem_rdata_i     (mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_win;
  logic       win_bit;

  initial begin
    rst_n = 1'b0;
    req_valid_i = '0; req_addr_i = '0; req_wdata_i = '0; req_w_en_i = '0;
    rsp_ready_i = '0; mem_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rdata_i = '0;

    // Reset state
    #12;
    chk("rst_mem_valid", {63'd0, mem_valid_o}, 64'd0);
    chk("rst_mem_addr", mem_addr_o, 64'd0);
    chk("rst_mem_wdata", mem_wdata_o, 64'd0);
    chk("rst_mem_w_en", {63'd0, mem_w_en_o}, 64'd0);
    chk("rst_req_ready", {62'd0, req_ready_o}, 64'd0);
    chk("rst_rsp_valid", {62'd0, rsp_valid_o}, 64'd0);
    chk("rst_mem_rsp_ready", {63'd0, mem_rsp_ready_o}, 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: single port-0 load
    mem_ready_i = 1'b1;
    req_valid_i = 2'b01; req_addr_i[0] = 64'h100; req_w_en_i = 2'b00;
    #1 chk("t1_req_ready", {62'd0, req_ready_o}, 64'h1);
    tick();
    req_valid_i = 2'b00;
    #1;
    chk("t1_mem_valid", {63'd0, mem_valid_o}, 64'd1);
    chk("t1_mem_addr", mem_addr_o, 64'h100);
    chk("t1_mem_w_en", {63'd0, mem_w_en_o}, 64'd0);
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 64'hAA; rsp_ready_i = 2'b11;
    #1;
    chk("t1_rsp_valid", {62'd0, rsp_valid_o}, 64'h1);
    chk("t1_rsp_rdata", rsp_rdata_o[0], 64'hAA);
    chk("t1_mem_rsp_ready", {63'd0, mem_rsp_ready_o}, 64'd1);
    tick();
    mem_rsp_valid_i = 1'b0;
    #1 chk("t1_mem_valid_drop", {63'd0, mem_valid_o}, 64'd0);

    // Reset again so port 0 wins the first tie
    rst_n = 1'b0;
    #1 chk("rst2_mem_valid", {63'd0, mem_valid_o}, 64'd0);
    rst_n = 1'b1;
    tick();

    // 2: both ports load every cycle
    req_valid_i = 2'b11; req_w_en_i = 2'b00;
    req_addr_i[0] = 64'h1000; req_addr_i[1] = 64'h2000;
    for (int i = 0; i < 4; i++) begin
`ifdef CPRV_ARB_FIXED_PRIO_EN
      win_bit = 1'b1;
`else
      win_bit = (i % 2 == 1);
`endif
      exp_win = win_bit ? 2'b10 : 2'b01;
      #1 chk("t2_req_ready", {62'd0, req_ready_o}, {62'd0, exp_win});
      tick();
      chk("t2_mem_addr", mem_addr_o, win_bit ? 64'h2000 : 64'h1000);
    end
    #1 chk("t2_full_ready", {62'd0, req_ready_o}, 64'd0);
    req_valid_i = 2'b00;
    tick();
    rsp_ready_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef CPRV_ARB_FIXED_PRIO_EN
      win_bit = 1'b1;
`else
      win_bit = (i % 2 == 1);
`endif
      exp_win = win_bit ? 2'b10 : 2'b01;
      mem_rsp_valid_i = 1'b1; mem_rdata_i = 64'h10 + 64'(i);
      #1;
      chk("t2_rsp_valid", {62'd0, rsp_valid_o}, {62'd0, exp_win});
      chk("t2_rsp_rdata", rsp_rdata_o[win_bit], 64'h10 + 64'(i));
      tick();
    end
    #1;
    chk("t2_empty_rsp_valid", {62'd0, rsp_valid_o}, 64'd0);
    chk("t2_empty_rsp_ready", {63'd0, mem_rsp_ready_o}, 64'd0);
    mem_rsp_valid_i = 1'b0;

    // 3: memory stall holds the output register
    req_valid_i = 2'b01; req_w_en_i = 2'b01;
    req_addr_i[0] = 64'h300; req_wdata_i[0] = 64'h77;
    #1 chk("t3_req_ready_store", {62'd0, req_ready_o}, 64'h1);
    tick();
    mem_ready_i = 1'b0;
    req_valid_i = 2'b11; req_addr_i[1] = 64'h400;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_stall_ready", {62'd0, req_ready_o}, 64'd0);
      chk("t3_stall_valid", {63'd0, mem_valid_o}, 64'd1);
      chk("t3_stall_addr", mem_addr_o, 64'h300);
      chk("t3_stall_wdata", mem_wdata_o, 64'h77);
      tick();
    end
    mem_ready_i = 1'b1;
    #1 chk("t3_release_ready", {62'd0, req_ready_o}, 64'h2);
    tick();
    req_valid_i = 2'b00;
    chk("t3_release_addr", mem_addr_o, 64'h400);
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 64'h99;
    #1 chk("t3_rsp_valid", {62'd0, rsp_valid_o}, 64'h2);
    tick();
    mem_rsp_valid_i = 1'b0;

    // 4: full FIFO blocks loads but not stores
    req_valid_i = 2'b01; req_w_en_i = 2'b00; req_addr_i[0] = 64'h500;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t4_load_ready", {62'd0, req_ready_o}, 64'h1);
      tick();
    end
    #1 chk("t4_full_ready", {62'd0, req_ready_o}, 64'd0);
    req_valid_i = 2'b11; req_w_en_i = 2'b10;
    req_addr_i[1] = 64'h200; req_wdata_i[1] = 64'h55;
    #1 chk("t4_store_ready", {62'd0, req_ready_o}, 64'h2);
    tick();
    req_valid_i = 2'b01;
    chk("t4_store_addr", mem_addr_o, 64'h200);
    chk("t4_store_wdata", mem_wdata_o, 64'h55);
    chk("t4_store_w_en", {63'd0, mem_w_en_o}, 64'd1);
    #1 chk("t4_still_full", {62'd0, req_ready_o}, 64'd0);
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 64'h01;
    #1;
    chk("t4_pop_rsp_valid", {62'd0, rsp_valid_o}, 64'h1);
    chk("t4_pop_before", {62'd0, req_ready_o}, 64'd0);
    tick();
    mem_rsp_valid_i = 1'b0;
    #1 chk("t4_load_after_pop", {62'd0, req_ready_o}, 64'h1);
    tick();
    req_valid_i = 2'b00;
    chk("t4_load_addr", mem_addr_o, 64'h500);

    // 5: head requester not ready stalls the response
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 64'hBEEF; rsp_ready_i = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_mem_rsp_ready", {63'd0, mem_rsp_ready_o}, 64'd0);
      chk("t5_rsp_valid", {62'd0, rsp_valid_o}, 64'h1);
      tick();
    end
    rsp_ready_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t5_drain", {63'd0, mem_rsp_ready_o}, 64'd1);
      tick();
    end
    #1 chk("t5_drained_empty", {63'd0, mem_rsp_ready_o}, 64'd0);
    mem_rsp_valid_i = 1'b0;

    // 6: both ports storing for 4 cycles
    req_valid_i = 2'b11; req_w_en_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef CPRV_ARB_FIXED_PRIO_EN
      exp_win = 2'b10;
`else
      // last grant before this phase was port 0
      exp_win = (i % 2 == 0) ? 2'b10 : 2'b01;
`endif
      #1 chk("t6_grant", {62'd0, req_ready_o}, {62'd0, exp_win});
      tick();
    end
    req_valid_i = 2'b00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
